uart_rx_sequencer: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX sequencer states, oversample default, baud-select codes.
// No logic; imported by the RX sequencer and by TX-side control.
// Baud-select codes are decoded by the baud generator, not here.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int RX_OVERSAMPLE = 16;

    localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
    localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
    localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
    localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async RX line plus falling-edge detector.
// Latency: rx_s lags rx_in by 2 cycles; rx_fall is a 1-cycle pulse. No backpressure.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle-high level so leaving reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART RX frame controller: gates the baud generator, samples mid-bit, deserializes LSB first.
// Latency: byte lands in the holding register 1 cycle after the stop-bit sample.
// Backpressure: rx_valid/rx_ready holding register; an unread byte is overwritten and flagged overrun_err. Parity via UART_RX_PARITY_EN.
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = RX_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 parity_odd,
    output logic                 baud_run,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] END_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .rx_in   (rx_in),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 load_q, load_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 framing_q, framing_d;
    logic                 overrun_q, overrun_d;
    logic                 counting;
    logic                 end_tick;

`ifdef UART_RX_PARITY_EN
    logic par_frame_q, par_frame_d;
    logic parity_q, parity_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign counting = state_q inside {START, DATA, PARITY, STOP};
    assign end_tick = baud_tick && (tick_cnt_q == END_TICK);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_bit_d = stop_bit_q;
        load_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_frame_d = par_frame_q;
`endif

        if (counting && baud_tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick && (tick_cnt_q == MID_TICK)) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (end_tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (end_tick) begin
`ifdef UART_RX_PARITY_EN
                    par_frame_d = ^shift_q ^ rx_s ^ parity_odd;
`endif
                    state_d = STOP;
                end
            end
            STOP: begin
                if (end_tick) begin
                    stop_bit_d = rx_s;
                    load_d     = 1'b1;
                    state_d    = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Held-low line must return high before another start edge counts.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        framing_d  = framing_q;
        overrun_d  = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // A load wins over a same-cycle accept; the accepted byte is not an overrun.
        if (load_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            framing_d  = ~stop_bit_q;
            overrun_d  = rx_valid_q & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_d   = par_frame_q;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_bit_q <= 1'b1;
            load_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            framing_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_frame_q <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_bit_q <= stop_bit_d;
            load_q     <= load_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            framing_q  <= framing_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_frame_q <= par_frame_d;
            parity_q    <= parity_d;
`endif
        end
    end

    assign baud_run    = counting;
    assign busy        = (state_q != IDLE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_q;
    assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: emulated baud generator, bit-timed serial driver, accept monitor.
// Expected bytes/flags come from frame-level rules (data, stop level, parity sum, unread byte).
module tb_uart_rx_sequencer;

    localparam int TICK_DIV = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = TICK_DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       oe;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pbit;
        logic       podd;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b0;
    logic       baud_run;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       parity_err;
    logic       overrun_err;

    int   errors = 0;
    int   checks = 0;
    int   valid_cycles = 0;
    obs_t got[$];
    obs_t expq[$];
    logic unused_pbit;

    uart_rx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clock       (clock),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .parity_odd  (parity_odd),
        .baud_run    (baud_run),
        .busy        (busy),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clock = ~clock;

    // Baud generator model: held cleared while baud_run is low.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clock);
            if (!baud_run) begin
                div = 0;
                baud_tick = 1'b0;
            end else begin
                baud_tick = (div == TICK_DIV - 1);
                div = (div == TICK_DIV - 1) ? 0 : div + 1;
            end
        end
    end

    // Accept monitor: records every byte the host actually takes.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got.push_back({rx_data, framing_err, parity_err, overrun_err});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clk(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
`else
        unused_pbit = pbit;
`endif
        send_bit(stop);
    endtask

    task automatic check_got(input string name, input obs_t exp);
        check({name, "_count"}, got.size(), 1);
        if (got.size() != 0) check(name, got.pop_front(), exp);
    endtask

    vec_t vecs[7];

    initial begin
        obs_t e;
        obs_t held_e;
        logic held;
        logic r, stp, pb;
        logic [7:0] d;
        int n;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, PAR_EN};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, PAR_EN};

        wait_clk(4);
        check("rst_baud_run", baud_run, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_errs", {framing_err, parity_err, overrun_err}, 0);
        reset = 1'b0;
        wait_clk(20);

        // Table-driven single frames, host always ready.
        rx_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            got.delete();
            valid_cycles = 0;
            parity_odd = vecs[v].podd;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].pbit);
            if (!vecs[v].stop) begin
                wait_clk(40 * TICK_DIV);
                check($sformatf("v%0d_break_busy", v), busy, 1);
                check($sformatf("v%0d_break_baud_run", v), baud_run, 0);
                rx_in = 1'b1;
                wait_clk(6);
            end
            wait_clk(32);
            check_got($sformatf("v%0d_frame", v), {vecs[v].exp_data, vecs[v].exp_fe, vecs[v].exp_pe, 1'b0});
            check($sformatf("v%0d_valid_cycles", v), valid_cycles, 1);
            check($sformatf("v%0d_baud_run_idle", v), baud_run, 0);
            check($sformatf("v%0d_busy_idle", v), busy, 0);
        end

        // Start-bit glitch of 4 tick periods.
        got.delete();
        valid_cycles = 0;
        rx_in = 1'b0;
        wait_clk(4 * TICK_DIV);
        rx_in = 1'b1;
        check("glitch_busy_start", busy, 1);
        check("glitch_baud_run_start", baud_run, 1);
        wait_clk(60);
        check("glitch_busy_end", busy, 0);
        check("glitch_baud_run_end", baud_run, 0);
        check("glitch_no_valid", valid_cycles, 0);

        // Overrun: two frames with the host stalled.
        rx_ready = 1'b0;
        parity_odd = 1'b0;
        got.delete();
        send_frame(8'h11, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("ovr_first", {rx_valid, rx_data, overrun_err}, {1'b1, 8'h11, 1'b0});
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("ovr_second", {rx_valid, rx_data, overrun_err}, {1'b1, 8'h22, 1'b1});
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(1);
        check("ovr_cleared", rx_valid, 0);
        check_got("ovr_accept", {8'h22, 1'b0, PAR_EN & 1'b0, 1'b1});

        // Reset mid-DATA (bit 4) with a byte held: both discarded.
        send_frame(8'h33, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("rst_held_valid", rx_valid, 1);
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_in = d[4];
        wait_clk(BIT_CLKS / 2);
        reset = 1'b1;
        rx_in = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        check("midrst_state", {busy, baud_run, rx_valid}, 0);
        check("midrst_data", rx_data, 0);
        wait_clk(2 * BIT_CLKS);
        check("midrst_no_accept", got.size(), 0);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, ^d);
        wait_clk(32);
        check_got("midrst_clean", {8'h5A, 1'b0, 1'b0, 1'b0});

        // Randomized frames against the frame-level model.
        got.delete();
        expq.delete();
        held = 1'b0;
        held_e = '0;
        n = 16;
        for (int k = 0; k < n; k++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            pb  = 1'($urandom);
            r   = 1'($urandom);
            parity_odd = 1'($urandom);
            rx_ready = r;
            if (r && held) begin
                expq.push_back(held_e);
                held = 1'b0;
            end
            e.data = d;
            e.fe   = ~stp;
            e.pe   = PAR_EN & (^d ^ pb ^ parity_odd);
            e.oe   = held;
            send_frame(d, stp, pb);
            if (!stp) begin
                wait_clk($urandom_range(0, 120));
                rx_in = 1'b1;
            end
            wait_clk($urandom_range(8, 80));
            if (r) begin
                expq.push_back(e);
            end else begin
                check($sformatf("rand%0d_held", k), {rx_valid, rx_data, framing_err, parity_err, overrun_err},
                      {1'b1, e});
                held = 1'b1;
                held_e = e;
            end
        end
        rx_ready = 1'b1;
        wait_clk(4);
        if (held) expq.push_back(held_e);
        check("rand_count", got.size(), expq.size());
        while (got.size() != 0 && expq.size() != 0) begin
            check("rand_frame", got.pop_front(), expq.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
